// File: rtl/change_dispatch_queue.sv
// Change-record FIFO feeding a compute core: each record is popped, announced
// with a one-cycle enable_change pulse, and the core's eoc handshake is awaited under a timeout.
module change_dispatch_queue #(
    parameter int IDX_W   = 16,
    parameter int ELEM_W  = 48,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IDX_W-1:0]           in_x,
    input  logic [IDX_W-1:0]           in_y,
    input  logic [ELEM_W-1:0]          in_elem,
    output logic                       enable_change,
    output logic [IDX_W-1:0]           x_out,
    output logic [IDX_W-1:0]           y_out,
    output logic [ELEM_W-1:0]          elem_out,
    input  logic                       eoc_flag,
    input  logic                       flush,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                done_count,
    output logic                       timeout_err
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WLOW  = 2'd2;
    localparam logic [1:0] S_WEOC  = 2'd3;

    typedef struct packed {
        logic [IDX_W-1:0]  x;
        logic [IDX_W-1:0]  y;
        logic [ELEM_W-1:0] elem;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             head_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]      done_q, done_d;
    logic             err_q, err_d;
    logic             push, pop, wait_hit;

    // A full FIFO refuses pushes even if a pop frees a slot in the same cycle.
    assign in_ready = (level_q < (AW+1)'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (level_q != '0) && eoc_flag && !flush;
    assign wait_hit = (wcnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= '{x: in_x, y: in_y, elem: in_elem};
    end

    always_comb begin
        level_d = level_q;
        if (flush)            level_d = '0;
        else if (push && !pop) level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = S_WLOW;
                wcnt_d  = '0;
            end
            S_WLOW: begin
                wcnt_d = wcnt_q + 1'b1;
                if (wait_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (!eoc_flag) begin
                    state_d = S_WEOC;
                end
            end
            default: begin
                // A completion arriving on the final wait cycle still counts.
                wcnt_d = wcnt_q + 1'b1;
                if (eoc_flag) begin
                    done_d  = done_q + 1'b1;
                    state_d = S_IDLE;
                end else if (wait_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            level_q <= level_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop) head_q <= mem[rd_ptr_q];
        end
    end

    assign enable_change = (state_q == S_ISSUE);
    assign busy          = (state_q != S_IDLE);
    assign x_out         = head_q.x;
    assign y_out         = head_q.y;
    assign elem_out      = head_q.elem;
    assign fifo_level    = level_q;
    assign done_count    = done_q;
    assign timeout_err   = err_q;
endmodule
